// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: CPU port, loader port and the shared memory lines.
// slave = arbiter view, master = requesters plus memory view.
interface mem_arbiter_if #(
   parameter int AW = 6,
   parameter int DW = 8
);
   logic          c_req;
   logic          c_we;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_wdata;
   logic [DW-1:0] c_rdata;
   logic          c_ack;

   logic          l_req;
   logic          l_we;
   logic          l_lock;
   logic [AW-1:0] l_addr;
   logic [DW-1:0] l_wdata;
   logic [DW-1:0] l_rdata;
   logic          l_ack;

   logic [AW-1:0] mem_addr;
   logic          mem_read;
   logic          mem_write;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  c_req, c_we, c_addr, c_wdata,
      output c_rdata, c_ack,
      input  l_req, l_we, l_lock, l_addr, l_wdata,
      output l_rdata, l_ack,
      output mem_addr, mem_read, mem_write, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output c_req, c_we, c_addr, c_wdata,
      input  c_rdata, c_ack,
      output l_req, l_we, l_lock, l_addr, l_wdata,
      input  l_rdata, l_ack,
      input  mem_addr, mem_read, mem_write, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin two-port (CPU / loader) arbiter in front of the 64x8 memory.
// Optional grant counters c_grants/l_grants are built when MEM_ARB_STATS_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a request; arbitrates and latches the granted request
// ACCESS | drives the memory strobe for one cycle and captures read data
// DONE   | one-cycle ack with read data to the owning port
module mem_arbiter #(
   parameter int AW = 6,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.slave  bus,
   output logic          owner,
`ifdef MEM_ARB_STATS_EN
   output logic [7:0]    c_grants,
   output logic [7:0]    l_grants,
`endif
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t        state_q, state_d;
   logic          owner_q, owner_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;

   logic grant_vld;
   logic grant_l;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= 1'b1;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      grant_vld = 1'b0;
      grant_l   = 1'b0;
      // A loader holding lock keeps the bus only once it already owns it.
      if (bus.l_req && bus.l_lock && owner_q) begin
         grant_vld = 1'b1;
         grant_l   = 1'b1;
      end else if (bus.c_req && bus.l_req) begin
         grant_vld = 1'b1;
         grant_l   = ~owner_q;
      end else if (bus.c_req) begin
         grant_vld = 1'b1;
         grant_l   = 1'b0;
      end else if (bus.l_req) begin
         grant_vld = 1'b1;
         grant_l   = 1'b1;
      end
   end

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      we_d          = we_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      rdata_d       = rdata_q;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.c_ack     = 1'b0;
      bus.l_ack     = 1'b0;
      bus.c_rdata   = '0;
      bus.l_rdata   = '0;

      case (state_q)
         IDLE: begin
            if (grant_vld) begin
               state_d = ACCESS;
               owner_d = grant_l;
               if (grant_l) begin
                  we_d    = bus.l_we;
                  addr_d  = bus.l_addr;
                  wdata_d = bus.l_wdata;
               end else begin
                  we_d    = bus.c_we;
                  addr_d  = bus.c_addr;
                  wdata_d = bus.c_wdata;
               end
            end
         end
         ACCESS: begin
            bus.mem_addr  = addr_q;
            bus.mem_wdata = wdata_q;
            bus.mem_read  = ~we_q;
            bus.mem_write = we_q;
            rdata_d       = we_q ? '0 : bus.mem_rdata;
            state_d       = DONE;
         end
         DONE: begin
            if (owner_q) begin
               bus.l_ack   = 1'b1;
               bus.l_rdata = rdata_q;
            end else begin
               bus.c_ack   = 1'b1;
               bus.c_rdata = rdata_q;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign owner = owner_q;
   assign busy  = (state_q != IDLE);

`ifdef MEM_ARB_STATS_EN
   logic [7:0] c_grants_q, c_grants_d;
   logic [7:0] l_grants_q, l_grants_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         c_grants_q <= '0;
         l_grants_q <= '0;
      end else begin
         c_grants_q <= c_grants_d;
         l_grants_q <= l_grants_d;
      end
   end

   always_comb begin
      c_grants_d = c_grants_q;
      l_grants_d = l_grants_q;
      if (state_q == IDLE && grant_vld) begin
         if (grant_l && l_grants_q != 8'hFF) l_grants_d = l_grants_q + 8'd1;
         if (!grant_l && c_grants_q != 8'hFF) c_grants_d = c_grants_q + 8'd1;
      end
   end

   assign c_grants = c_grants_q;
   assign l_grants = l_grants_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single-access vector table plus round-robin,
// lock, async-reset and (with MEM_ARB_STATS_EN) grant-counter sequences.
module tb_mem_arbiter;

   logic clk;
   logic reset;
   logic owner;
   logic busy;
`ifdef MEM_ARB_STATS_EN
   logic [7:0] c_grants;
   logic [7:0] l_grants;
`endif

   mem_arbiter_if #(.AW(6), .DW(8)) bus ();

   mem_arbiter #(.AW(6), .DW(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .owner    (owner),
`ifdef MEM_ARB_STATS_EN
      .c_grants (c_grants),
      .l_grants (l_grants),
`endif
      .busy     (busy)
   );

   logic [7:0] mem [64];
   assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr] : 8'h00;
   always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic       port;
      logic       we;
      logic [5:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout expected=ack", name);
   endtask

   task automatic run_access(input vec_t v);
      int  strobe_cyc;
      bit  done;
      strobe_cyc = -10;
      done = 0;
      @(negedge clk);
      if (!v.port) begin
         bus.c_req = 1; bus.c_we = v.we; bus.c_addr = v.addr; bus.c_wdata = v.wdata;
      end else begin
         bus.l_req = 1; bus.l_we = v.we; bus.l_addr = v.addr; bus.l_wdata = v.wdata;
      end
      for (int cyc = 0; cyc < 10 && !done; cyc++) begin
         @(negedge clk);
         if (bus.mem_read || bus.mem_write) begin
            strobe_cyc = cyc;
            check("mem_addr", 32'(bus.mem_addr), 32'(v.addr));
            check("mem_write", 32'(bus.mem_write), 32'(v.we));
            check("mem_read", 32'(bus.mem_read), 32'(!v.we));
            check("busy", 32'(busy), 1);
            if (v.we) check("mem_wdata", 32'(bus.mem_wdata), 32'(v.wdata));
         end
         if ((!v.port && bus.c_ack) || (v.port && bus.l_ack)) begin
            done = 1;
            check("ack_after_strobe", 32'(cyc - strobe_cyc), 1);
            check("rdata", v.port ? 32'(bus.l_rdata) : 32'(bus.c_rdata), 32'(v.exp_rdata));
            check("other_ack", v.port ? 32'(bus.c_ack) : 32'(bus.l_ack), 0);
            check("owner", 32'(owner), 32'(v.port));
            bus.c_req = 0;
            bus.l_req = 0;
         end
      end
      if (!done) begin
         timeout("single_access");
         bus.c_req = 0;
         bus.l_req = 0;
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
   endtask

   // Holds both requests (lock optional) and records ack order/times until n_acks seen.
   task automatic run_contention(input int n_acks, input bit lock_seq);
      logic  port_seen [8];
      int    time_seen [8];
      int    n;
      string nm;
      n = 0;
      for (int cyc = 0; cyc < 80 && n < n_acks; cyc++) begin
         @(negedge clk);
         if (bus.c_ack && bus.l_ack) check("ack_overlap", 32'(bus.l_ack), 0);
         if (bus.c_ack || bus.l_ack) begin
            port_seen[n] = bus.l_ack;
            time_seen[n] = cyc;
            n++;
            if (lock_seq && n == 4) bus.l_lock = 0;
            if (n == n_acks) begin
               bus.c_req = 0;
               bus.l_req = 0;
               bus.l_lock = 0;
            end
         end
      end
      if (n < n_acks) begin
         timeout("contention");
         bus.c_req = 0; bus.l_req = 0; bus.l_lock = 0;
      end else begin
         for (int i = 0; i < n_acks; i++) begin
            nm = $sformatf("grant_order_%0d", i);
            if (lock_seq) check(nm, 32'(port_seen[i]), (i == 0 || i == 4) ? 0 : 1);
            else          check(nm, 32'(port_seen[i]), 32'(i % 2));
            if (i > 0) check($sformatf("ack_spacing_%0d", i), 32'(time_seen[i] - time_seen[i-1]), 3);
         end
      end
   endtask

   task automatic cpu_quiet_read(input logic [5:0] a);
      bit done;
      done = 0;
      @(negedge clk);
      bus.c_req = 1; bus.c_we = 0; bus.c_addr = a;
      for (int cyc = 0; cyc < 10 && !done; cyc++) begin
         @(negedge clk);
         if (bus.c_ack) begin
            done = 1;
            bus.c_req = 0;
         end
      end
      if (!done) begin
         timeout("stats_access");
         bus.c_req = 0;
      end
   endtask

   initial begin
      bit seen_write;

      vecs[0] = '{1'b0, 1'b0, 6'h05, 8'h00, 8'hA7};
      vecs[1] = '{1'b1, 1'b1, 6'h3F, 8'h5C, 8'h00};
      vecs[2] = '{1'b0, 1'b0, 6'h3F, 8'h00, 8'h5C};
      vecs[3] = '{1'b1, 1'b0, 6'h05, 8'h00, 8'hA7};
      vecs[4] = '{1'b0, 1'b1, 6'h00, 8'hFF, 8'h00};
      vecs[5] = '{1'b1, 1'b0, 6'h00, 8'h00, 8'hFF};
      vecs[6] = '{1'b0, 1'b1, 6'h3F, 8'h01, 8'h00};
      vecs[7] = '{1'b1, 1'b0, 6'h3F, 8'h00, 8'h01};

      for (int i = 0; i < 64; i++) mem[i] = 8'h00;
      mem[5]  = 8'hA7;
      mem[16] = 8'h11;

      reset = 1;
      bus.c_req = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_wdata = '0;
      bus.l_req = 0; bus.l_we = 0; bus.l_lock = 0; bus.l_addr = '0; bus.l_wdata = '0;
      repeat (2) @(negedge clk);
      check("rst_c_ack", 32'(bus.c_ack), 0);
      check("rst_l_ack", 32'(bus.l_ack), 0);
      check("rst_mem_read", 32'(bus.mem_read), 0);
      check("rst_mem_write", 32'(bus.mem_write), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_rdata", {16'h0, bus.c_rdata, bus.l_rdata}, 0);
      check("rst_mem_addr", 32'(bus.mem_addr), 0);
      check("rst_mem_wdata", 32'(bus.mem_wdata), 0);
      check("rst_owner", 32'(owner), 1);
      reset = 0;

      for (int i = 0; i < 8; i++) run_access(vecs[i]);

      // Round-robin from reset: C wins the first tie.
      apply_reset();
      @(negedge clk);
      bus.c_req = 1; bus.c_we = 0; bus.c_addr = 6'h05;
      bus.l_req = 1; bus.l_we = 0; bus.l_addr = 6'h3F;
      run_contention(4, 1'b0);

      // Lock: C granted first, then L three times, lock drops, C again.
      apply_reset();
      @(negedge clk);
      bus.c_req = 1; bus.c_we = 0; bus.c_addr = 6'h05;
      @(negedge clk);
      bus.l_req = 1; bus.l_lock = 1; bus.l_we = 0; bus.l_addr = 6'h3F;
      run_contention(5, 1'b1);

      // Async reset during the ACCESS cycle of a CPU write.
      repeat (2) @(negedge clk);
      bus.c_req = 1; bus.c_we = 1; bus.c_addr = 6'h10; bus.c_wdata = 8'hEE;
      seen_write = 0;
      for (int cyc = 0; cyc < 10 && !seen_write; cyc++) begin
         @(negedge clk);
         if (bus.mem_write) seen_write = 1;
      end
      if (!seen_write) timeout("reset_write_strobe");
      #1 reset = 1;
      #1;
      check("arst_mem_write", 32'(bus.mem_write), 0);
      check("arst_busy", 32'(busy), 0);
      check("arst_c_ack", 32'(bus.c_ack), 0);
      check("arst_mem_addr", 32'(bus.mem_addr), 0);
      check("arst_owner", 32'(owner), 1);
      bus.c_req = 0;
      @(negedge clk);
      @(negedge clk);
      reset = 0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         @(negedge clk);
         check("post_rst_c_ack", 32'(bus.c_ack), 0);
         check("post_rst_busy", 32'(busy), 0);
      end
      check("post_rst_owner", 32'(owner), 1);
      check("mem_not_written", 32'(mem[16]), 32'h11);

`ifdef MEM_ARB_STATS_EN
      apply_reset();
      for (int i = 0; i < 300; i++) cpu_quiet_read(6'(i));
      @(negedge clk);
      check("c_grants_sat", 32'(c_grants), 255);
      check("l_grants_zero", 32'(l_grants), 0);
      apply_reset();
      check("c_grants_rst", 32'(c_grants), 0);
      check("l_grants_rst", 32'(l_grants), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
